lsu_split: RTL and testbench

LSU_SPLIT -- requirements
Module: lsu_split

---
 rtl/lsu_split.sv | 158 +++++++++++++++
 tb/tb_lsu_split.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_split.sv
// Load/store unit front end: splits misaligned half/word accesses into
// aligned word reads or byte writes toward a single-ported data memory.
//
// state  | meaning
// IDLE   | waiting for a request (req_ready high once out of reset)
// ISSUE0 | drive first read (aligned access, or low word of a split load)
// ISSUE1 | capture low word, drive read of the following word
// CAP1   | capture last read word into rsp_rdata
// WR     | one store cycle (full store, or one byte of a split store)
// RSP    | one-cycle completion pulse
module lsu_split (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_memop,
  input  logic        req_we,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout,
  output logic [15:0] mis_cnt
);

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAP1, WR, RSP} state_t;

  state_t      state_q, state_d;
  logic        init_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  memop_q;
  logic        mis_q;
  logic [1:0]  idx_q;
  logic [31:0] word0_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [15:0] mis_cnt_q;

  logic        accept;
  logic        req_illegal;
  logic        req_mis;
  logic [1:0]  last_idx;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic [7:0]  wbyte;
  logic [31:0] word_base;

  assign req_ready = init_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign req_illegal = (req_memop == 3'b011) || (req_memop == 3'b110) ||
                       (req_memop == 3'b111) || (req_we && (req_memop[1:0] == 2'b11));
  assign req_mis     = ((req_memop[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                       ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  // Split stores: two bytes for a halfword, four for a word.
  assign last_idx  = (memop_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign word_base = {addr_q[31:2], 2'b00};
  assign wbyte     = 8'(wdata_q >> {idx_q, 3'b000});
  assign merged    = 32'({mem_dataout, word0_q} >> {addr_q[1:0], 3'b000});
  assign load_val  = (memop_q[1:0] == 2'b10) ? merged :
                     {{16{~memop_q[2] & merged[15]}}, merged[15:0]};

  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mis_cnt   = mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      memop_q     <= 3'b010;
      mis_q       <= 1'b0;
      idx_q       <= '0;
      word0_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mis_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        memop_q   <= req_memop;
        mis_q     <= req_mis && !req_illegal;
        idx_q     <= '0;
        rsp_err_q <= req_illegal;
        if (req_mis && !req_illegal && (mis_cnt_q != 16'hFFFF))
          mis_cnt_q <= mis_cnt_q + 16'd1;
      end
      if (state_q == WR)
        idx_q <= idx_q + 2'd1;
      if (state_q == ISSUE1)
        word0_q <= mem_dataout;
      if (state_q == CAP1)
        rsp_rdata_q <= mis_q ? load_val : mem_dataout;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_memop  = 3'b010;
    mem_datain = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_illegal)  state_d = RSP;
          else if (req_we)  state_d = WR;
          else              state_d = ISSUE0;
        end
      end
      ISSUE0: begin
        if (mis_q) begin
          mem_addr = word_base;
          state_d  = ISSUE1;
        end else begin
          mem_addr  = addr_q;
          mem_memop = memop_q;
          state_d   = CAP1;
        end
      end
      ISSUE1: begin
        mem_addr = word_base + 32'd4;
        state_d  = CAP1;
      end
      CAP1: state_d = RSP;
      WR: begin
        mem_we = 1'b1;
        if (mis_q) begin
          mem_addr   = addr_q + {30'd0, idx_q};
          mem_memop  = 3'b000;
          mem_datain = {24'd0, wbyte};
          state_d    = (idx_q == last_idx) ? RSP : WR;
        end else begin
          mem_addr   = addr_q;
          mem_memop  = {1'b0, memop_q[1:0]};
          mem_datain = wdata_q;
          state_d    = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_split.sv
// Randomized bench for lsu_split: a byte-addressed memory device plus a
// request-level reference model predicting every cycle of each transaction.
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_memop;
  logic        req_we;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic [31:0] mem_dataout = 32'h0;
  logic [15:0] mis_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_rdata;
  logic        m_err;
  logic [15:0] m_cnt;

  logic [7:0] mem_dut [logic [31:0]];
  logic [7:0] mem_ref [logic [31:0]];

  localparam logic [69:0] IDLE_BUS = {1'b0, 1'b0, 1'b0, 32'h0, 3'b010, 32'h0};

  always #5 clk = ~clk;

  lsu_split dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_memop(req_memop), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop), .mem_we(mem_we),
    .mem_dataout(mem_dataout), .mis_cnt(mis_cnt)
  );

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic logic [7:0] dut_byte(input logic [31:0] a);
    return mem_dut.exists(a) ? mem_dut[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : dflt(a);
  endfunction

  function automatic int op_size(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Value a memory access of type op returns from four little-endian bytes.
  function automatic logic [31:0] fmt_load(input logic [7:0] b0, b1, b2, b3, input logic [2:0] op);
    case (op[1:0])
      2'b00:   return op[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   return op[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < op_size(mem_memop); i++)
        mem_dut[mem_addr + 32'(i)] = mem_datain[8*i +: 8];
    end else begin
      mem_dataout <= fmt_load(dut_byte(mem_addr), dut_byte(mem_addr + 32'd1),
                              dut_byte(mem_addr + 32'd2), dut_byte(mem_addr + 32'd3), mem_memop);
    end
  end

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem_dut[a + 32'(i)] = w[8*i +: 8];
      mem_ref[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after RSP.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op, input logic we);
    logic        ill, mis;
    int          lat, n;
    logic [69:0] exp_q [$];
    logic [69:0] t;
    logic [31:0] w;
    ill = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[1:0] == 2'b11);
    mis = !ill && ((op[1:0] == 2'b01 && a[1:0] == 2'b11) || (op[1:0] == 2'b10 && a[1:0] != 2'b00));
    w   = a & 32'hFFFF_FFFC;
    if (ill) begin
      lat = 1;
    end else if (!we) begin
      if (mis) begin
        exp_q.push_back({1'b0, 1'b0, 1'b0, w, 3'b010, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 1'b0, w + 32'd4, 3'b010, 32'h0});
        lat = 4;
      end else begin
        exp_q.push_back({1'b0, 1'b0, 1'b0, a, op, 32'h0});
        lat = 3;
      end
      m_rdata = fmt_load(ref_byte(a), ref_byte(a + 32'd1), ref_byte(a + 32'd2), ref_byte(a + 32'd3), op);
    end else if (!mis) begin
      exp_q.push_back({1'b0, 1'b0, 1'b1, a, {1'b0, op[1:0]}, wd});
      for (int i = 0; i < op_size(op); i++) mem_ref[a + 32'(i)] = wd[8*i +: 8];
      lat = 2;
    end else begin
      n = (op[1:0] == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({1'b0, 1'b0, 1'b1, a + 32'(i), 3'b000, 24'h0, wd[8*i +: 8]});
        mem_ref[a + 32'(i)] = wd[8*i +: 8];
      end
      lat = n + 1;
    end
    while (exp_q.size() < lat) exp_q.push_back(IDLE_BUS);
    t = exp_q[lat-1];
    t[68] = 1'b1;
    exp_q[lat-1] = t;
    m_err = ill;
    if (mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;

    req_addr = a; req_wdata = wd; req_memop = op; req_we = we; req_valid = 1'b1;
    chk("accept_ready", {69'h0, req_ready}, 70'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom; req_wdata = $urandom;
    req_memop = 3'($urandom); req_we = 1'($urandom);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk($sformatf("bus a=%h op=%0d we=%0d cyc%0d", a, op, we, c + 1),
          {req_ready, rsp_valid, mem_we, mem_addr, mem_memop, mem_datain}, exp_q[c]);
    end
    chk("rsp_rdata", {38'h0, rsp_rdata}, {38'h0, m_rdata});
    chk("rsp_err", {69'h0, rsp_err}, {69'h0, m_err});
    chk("mis_cnt", {54'h0, mis_cnt}, {54'h0, m_cnt});
    @(negedge clk);
    chk("post_rsp", {68'h0, req_ready, rsp_valid}, 70'h2);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0;
    req_addr = '0; req_wdata = '0; req_memop = '0; req_we = 1'b0;
    m_rdata = '0; m_err = 1'b0; m_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset_bus", {req_ready, rsp_valid, mem_we, mem_addr, mem_memop, mem_datain}, IDLE_BUS);
    chk("reset_rdata", {38'h0, rsp_rdata}, 70'h0);
    chk("reset_err_cnt", {53'h0, rsp_err, mis_cnt}, 70'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {69'h0, req_ready}, 70'h1);

    put_word(32'h10, 32'h8899AABB);
    do_req(32'h10, 32'h0, 3'b010, 1'b0);
    put_word(32'h10, 32'h11223344);
    put_word(32'h14, 32'h55667788);
    do_req(32'h13, 32'h0, 3'b001, 1'b0);
    chk("lh_0x13", {38'h0, rsp_rdata}, {38'h0, 32'hFFFF8811});
    do_req(32'h13, 32'h0, 3'b101, 1'b0);
    chk("lhu_0x13", {38'h0, rsp_rdata}, {38'h0, 32'h00008811});
    do_req(32'h21, 32'hDEADBEEF, 3'b010, 1'b1);
    chk("sw_bytes", {38'h0, dut_byte(32'h24), dut_byte(32'h23), dut_byte(32'h22), dut_byte(32'h21)},
        {38'h0, 32'hDEADBEEF});
    do_req(32'h40, 32'h0, 3'b011, 1'b0);
    do_req(32'h40, 32'h12345678, 3'b111, 1'b1);
    do_req(32'hFFFFFFFF, 32'hA5C3, 3'b001, 1'b1);
    do_req(32'hFFFFFFFE, 32'h0, 3'b010, 1'b0);

    // Reset during the second byte write of a split word store.
    req_addr = 32'h41; req_wdata = 32'hCAFEF00D; req_memop = 3'b010; req_we = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("second_wr", {req_ready, rsp_valid, mem_we, mem_addr, mem_memop, mem_datain},
        {1'b0, 1'b0, 1'b1, 32'h42, 3'b000, 32'hF0});
    rst_n = 1'b0;
    #1;
    chk("reset_mid_bus", {req_ready, rsp_valid, mem_we, mem_addr, mem_memop, mem_datain}, IDLE_BUS);
    mem_ref[32'h41] = 8'h0D;
    for (int i = 0; i < 4; i++)
      chk("reset_mid_mem", {62'h0, dut_byte(32'h41 + 32'(i))}, {62'h0, ref_byte(32'h41 + 32'(i))});
    repeat (2) begin
      @(negedge clk);
      chk("no_rsp_in_reset", {69'h0, rsp_valid}, 70'h0);
    end
    rst_n = 1'b1;
    m_rdata = '0; m_err = 1'b0; m_cnt = '0;
    @(negedge clk);
    chk("ready_after_mid_reset", {69'h0, req_ready}, 70'h1);
    chk("cnt_after_mid_reset", {54'h0, mis_cnt}, 70'h0);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_req(a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    force dut.mis_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.mis_cnt_q;
    m_cnt = 16'hFFFF;
    chk("cnt_preload", {54'h0, mis_cnt}, {54'h0, 16'hFFFF});
    do_req(32'h102, 32'h0, 3'b010, 1'b0);
    do_req(32'h103, 32'h77, 3'b001, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
